// File: rtl/ticker_multi.sv
// ticker_multi: multi-channel one-hot LED ticker with a shared prescaler,
// per-channel stuck-at fault injection and a golden-vs-output checker.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   en, dir              tick enable, rotation direction (0 = left, 1 = right)
//   fault_en[CHANNELS]   per-channel injection enable
//   fault_mask[WIDTH]    bits forced on injected channels
//   fault_val            stuck-at value for masked bits
//   clr_err              clears err and err_count
//   pattern              registered channel patterns, channel k at [k*WIDTH +: WIDTH]
//   err, err_any         sticky per-channel mismatch flags and their OR
//   err_count            saturating count of cycles with any mismatch
module ticker_multi #(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 2,
    parameter int DIV      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      dir,
    input  logic [CHANNELS-1:0]       fault_en,
    input  logic [WIDTH-1:0]          fault_mask,
    input  logic                      fault_val,
    input  logic                      clr_err,
    output logic [CHANNELS*WIDTH-1:0] pattern,
    output logic [CHANNELS-1:0]       err,
    output logic                      err_any,
    output logic [7:0]                err_count
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0]                    presc;
    logic                             tick;
    logic [CHANNELS-1:0][WIDTH-1:0]   golden;
    logic [CHANNELS-1:0][WIDTH-1:0]   golden_d;
    logic [CHANNELS-1:0][WIDTH-1:0]   forced;
    logic [CHANNELS-1:0]              mismatch;

    function automatic logic [WIDTH-1:0] seed(input int k);
        logic [WIDTH-1:0] s;
        s = '0;
        s[k % WIDTH] = 1'b1;
        return s;
    endfunction

    always_comb begin
        tick     = en && (presc == LAST);
        forced   = golden;
        mismatch = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (fault_en[k]) begin
                forced[k] = (golden[k] & ~fault_mask)
                          | (fault_mask & {WIDTH{fault_val}});
            end
            // golden_d is the golden value that produced the current pattern
            mismatch[k] = pattern[k*WIDTH +: WIDTH] != golden_d[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            err       <= '0;
            err_count <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                golden[k]                  <= seed(k);
                golden_d[k]                <= seed(k);
                pattern[k*WIDTH +: WIDTH]  <= seed(k);
            end
        end else begin
            if (en) begin
                presc <= (presc == LAST) ? '0 : presc + 1'b1;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (tick) begin
                    golden[k] <= dir
                        ? {golden[k][0], golden[k][WIDTH-1:1]}
                        : {golden[k][WIDTH-2:0], golden[k][WIDTH-1]};
                end
                golden_d[k]               <= golden[k];
                pattern[k*WIDTH +: WIDTH] <= forced[k];
            end
            // clear wins over a mismatch seen in the same cycle
            if (clr_err) begin
                err       <= '0;
                err_count <= '0;
            end else begin
                err <= err | mismatch;
                if (|mismatch && err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

    assign err_any = |err;

endmodule

// File: tb/tb_ticker_multi.sv
// tb_ticker_multi: self-checking bench for ticker_multi (WIDTH=3,
// CHANNELS=2, DIV=4) using a directed vector table and a model scoreboard.
module tb_ticker_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] fault_en = '0;
    logic [2:0] fault_mask = '0;
    logic       fault_val = 1'b0;
    logic       clr_err = 1'b0;
    logic [5:0] pattern;
    logic [1:0] err;
    logic       err_any;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    ticker_multi #(.WIDTH(3), .CHANNELS(2), .DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir),
        .fault_en(fault_en), .fault_mask(fault_mask),
        .fault_val(fault_val), .clr_err(clr_err),
        .pattern(pattern), .err(err), .err_any(err_any),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       e;
        logic       d;
        logic [1:0] fe;
        logic [2:0] fm;
        logic       fv;
        logic       clr;
        int         n;
        logic [5:0] x_pat;
        logic [1:0] x_err;
        logic [7:0] x_cnt;
    } vec_t;

    typedef struct {
        logic [5:0] pat;
        logic [1:0] err;
        logic       any;
        logic [7:0] cnt;
    } exp_t;

    exp_t sbq[$];

    // reference model: ch0 golden is one-hot at position m_pos,
    // ch1 sits one position higher
    int         m_presc, m_pos, m_pos_d, m_cnt;
    logic [5:0] m_pat;
    logic [1:0] m_err;

    function automatic logic [2:0] gold(input int pos, input int k);
        logic [2:0] one;
        one = 3'b001;
        return one << ((pos + k) % 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic drive(input logic r, e, d, input logic [1:0] fe,
                         input logic [2:0] fm, input logic fv, clr);
        rst = r; en = e; dir = d; fault_en = fe;
        fault_mask = fm; fault_val = fv; clr_err = clr;
    endtask

    task automatic model_step(input logic r, e, d, input logic [1:0] fe,
                              input logic [2:0] fm, input logic fv, clr);
        logic [1:0] mism;
        logic [2:0] g;
        exp_t x;
        if (r) begin
            m_presc = 0; m_pos = 0; m_pos_d = 0;
            m_pat = {gold(0, 1), gold(0, 0)};
            m_err = '0; m_cnt = 0;
        end else begin
            for (int k = 0; k < 2; k++)
                mism[k] = m_pat[k*3 +: 3] != gold(m_pos_d, k);
            if (clr) begin
                m_err = '0; m_cnt = 0;
            end else begin
                m_err = m_err | mism;
                if (mism != 2'b00 && m_cnt < 255) m_cnt++;
            end
            for (int k = 0; k < 2; k++) begin
                g = gold(m_pos, k);
                for (int b = 0; b < 3; b++)
                    if (fe[k] && fm[b]) g[b] = fv;
                m_pat[k*3 +: 3] = g;
            end
            m_pos_d = m_pos;
            if (e) begin
                if (m_presc == 3) m_pos = d ? (m_pos + 2) % 3 : (m_pos + 1) % 3;
                m_presc = (m_presc + 1) % 4;
            end
        end
        x.pat = m_pat; x.err = m_err; x.any = |m_err; x.cnt = 8'(m_cnt);
        sbq.push_back(x);
    endtask

    task automatic sb_cycle(input logic r, e, d, input logic [1:0] fe,
                            input logic [2:0] fm, input logic fv, clr);
        exp_t x;
        @(negedge clk);
        drive(r, e, d, fe, fm, fv, clr);
        model_step(r, e, d, fe, fm, fv, clr);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            x = sbq.pop_front();
            chk("sb_pattern", 32'(pattern), 32'(x.pat));
            chk("sb_err", 32'(err), 32'(x.err));
            chk("sb_err_any", 32'(err_any), 32'(x.any));
            chk("sb_err_count", 32'(err_count), 32'(x.cnt));
        end
    endtask

    initial begin
        vec_t tbl[$];

        // directed sequence; expected values are after each edge
        tbl.push_back('{1, 0, 0, 2'b00, 3'b000, 0, 0, 5, 6'b010001, 2'b00, 8'd0});
        tbl.push_back('{0, 1, 0, 2'b00, 3'b000, 0, 0, 4, 6'b010001, 2'b00, 8'd0});
        tbl.push_back('{0, 1, 0, 2'b00, 3'b000, 0, 0, 4, 6'b100010, 2'b00, 8'd0});
        tbl.push_back('{0, 1, 0, 2'b00, 3'b000, 0, 0, 4, 6'b001100, 2'b00, 8'd0});
        tbl.push_back('{0, 1, 0, 2'b00, 3'b000, 0, 0, 4, 6'b010001, 2'b00, 8'd0});
        tbl.push_back('{0, 1, 0, 2'b00, 3'b000, 0, 0, 4, 6'b100010, 2'b00, 8'd0});
        tbl.push_back('{0, 1, 0, 2'b00, 3'b000, 0, 0, 1, 6'b001100, 2'b00, 8'd0});
        // dir flips mid-interval; ch0 100 goes to 010 at the next tick
        tbl.push_back('{0, 1, 1, 2'b00, 3'b000, 0, 0, 3, 6'b001100, 2'b00, 8'd0});
        tbl.push_back('{0, 1, 1, 2'b00, 3'b000, 0, 0, 4, 6'b100010, 2'b00, 8'd0});
        tbl.push_back('{0, 1, 1, 2'b00, 3'b000, 0, 0, 1, 6'b010001, 2'b00, 8'd0});
        // SA0 on ch0 bit 0 while ch0 = 001
        tbl.push_back('{0, 0, 0, 2'b01, 3'b001, 0, 0, 1, 6'b010000, 2'b00, 8'd0});
        tbl.push_back('{0, 0, 0, 2'b01, 3'b001, 0, 0, 1, 6'b010000, 2'b01, 8'd1});
        tbl.push_back('{0, 0, 0, 2'b01, 3'b001, 0, 0, 1, 6'b010000, 2'b01, 8'd2});
        tbl.push_back('{0, 0, 0, 2'b00, 3'b001, 0, 0, 1, 6'b010001, 2'b01, 8'd3});
        tbl.push_back('{0, 0, 0, 2'b00, 3'b001, 0, 0, 1, 6'b010001, 2'b01, 8'd3});
        tbl.push_back('{0, 0, 0, 2'b00, 3'b000, 0, 1, 1, 6'b010001, 2'b00, 8'd0});
        tbl.push_back('{0, 0, 0, 2'b00, 3'b000, 0, 0, 1, 6'b010001, 2'b00, 8'd0});
        // SA0 on a bit already 0 must not flag
        tbl.push_back('{0, 0, 0, 2'b10, 3'b001, 0, 0, 2, 6'b010001, 2'b00, 8'd0});

        for (int i = 0; i < tbl.size(); i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                @(negedge clk);
                drive(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].fe,
                      tbl[i].fm, tbl[i].fv, tbl[i].clr);
                @(posedge clk);
                #1;
                chk($sformatf("vec%0d.%0d pattern", i, j),
                    32'(pattern), 32'(tbl[i].x_pat));
                chk($sformatf("vec%0d.%0d err", i, j),
                    32'(err), 32'(tbl[i].x_err));
                chk($sformatf("vec%0d.%0d err_any", i, j),
                    32'(err_any), 32'(tbl[i].x_err != 2'b00));
                chk($sformatf("vec%0d.%0d err_count", i, j),
                    32'(err_count), 32'(tbl[i].x_cnt));
            end
        end

        // scoreboard phase: reset, then random stimulus
        sb_cycle(1, 0, 0, 2'b00, 3'b000, 0, 0);
        for (int i = 0; i < 400; i++) begin
            sb_cycle(($urandom_range(63) == 0), ($urandom_range(3) != 0),
                     1'($urandom), 2'($urandom), 3'($urandom),
                     1'($urandom), ($urandom_range(15) == 0));
        end

        // saturation with both channels SA1 on every bit
        sb_cycle(1, 0, 0, 2'b00, 3'b000, 0, 0);
        for (int i = 0; i < 300; i++)
            sb_cycle(0, 1, 0, 2'b11, 3'b111, 1, 0);
        chk("sat_count", 32'(err_count), 32'd255);
        chk("sat_err", 32'(err), 32'd3);
        chk("sat_any", 32'(err_any), 32'd1);
        sb_cycle(0, 1, 0, 2'b11, 3'b111, 1, 1);
        chk("clr_count", 32'(err_count), 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        sb_cycle(0, 1, 0, 2'b11, 3'b111, 1, 0);
        chk("rerecord_count", 32'(err_count), 32'd1);

        // reset during active injection with err set
        sb_cycle(0, 1, 0, 2'b11, 3'b111, 1, 0);
        sb_cycle(1, 1, 1, 2'b11, 3'b111, 1, 1);
        chk("rst_pattern", 32'(pattern), 32'h11);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_count", 32'(err_count), 32'd0);
        sb_cycle(0, 1, 0, 2'b11, 3'b111, 1, 0);
        chk("post_rst_err", 32'(err), 32'd0);
        sb_cycle(0, 1, 0, 2'b11, 3'b111, 1, 0);
        chk("post_rst_flag", 32'(err), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
